// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, S-box table and byte/word helper functions
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;
  localparam logic [3:0] NR = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
endpackage

// File: rtl/aes128_round_sched_if.sv
// aes128_round_sched_if: block-in / ciphertext-out valid/ready bus
interface aes128_round_sched_if;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_key, in_block, out_data;
  modport master(output in_valid, in_key, in_block, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_key, in_block, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes128_round_step.sv
// aes128_round_step: one combinational AES round plus on-the-fly key expansion
module aes128_round_step
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         final_round,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);
  logic [127:0] sr, mc;
  logic [31:0] t;
  assign t = sub_word({key[23:0], key[31:24]}) ^ {rcon, 24'h0};
  assign next_key[127:96] = key[127:96] ^ t;
  assign next_key[95:64]  = key[95:64] ^ next_key[127:96];
  assign next_key[63:32]  = key[63:32] ^ next_key[95:64];
  assign next_key[31:0]   = key[31:0] ^ next_key[63:32];
  // SubBytes+ShiftRows, then MixColumns; byte index is 4*column+row from the MSB
  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[8*(15-(4*c+r)) +: 8] = SBOX[state[8*(15-(4*((c+r)%4)+r)) +: 8]];
    for (int c = 0; c < 4; c++)
      mc[32*(3-c) +: 32] = mix_col(sr[32*(3-c) +: 32]);
  end
  assign next_state = (final_round ? sr : mc) ^ next_key;
endmodule

// File: rtl/aes128_round_sched.sv
// aes128_round_sched: iterative AES-128 encryptor sequencing one round datapath over ten cycles
module aes128_round_sched
  import aes_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  aes128_round_sched_if.slave       bus,
  output logic                      busy,
  output logic [3:0]                round_idx
);
  state_e st_q;
  logic [127:0] state_q, key_q, nxt_state, nxt_key;
  logic [7:0] rcon_q;
  logic [3:0] round_q;
  logic in_ready_q, out_valid_q, last;
  assign last = round_q == NR;
  aes128_round_step u_step (
    .state(state_q), .key(key_q), .rcon(rcon_q), .final_round(last),
    .next_state(nxt_state), .next_key(nxt_key)
  );
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_valid_q ? state_q : '0;
  assign round_idx = round_q;
  // Controller FSM: accept, run ten rounds, hold ciphertext until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      state_q <= '0;
      key_q <= '0;
      rcon_q <= RCON_INIT;
      round_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (bus.in_valid) begin
          state_q <= bus.in_block ^ bus.in_key;
          key_q <= bus.in_key;
          rcon_q <= RCON_INIT;
          round_q <= 4'd1;
          st_q <= ROUND;
          in_ready_q <= 1'b0;
          busy <= 1'b1;
        end
        ROUND: begin
          state_q <= nxt_state;
          key_q <= nxt_key;
          rcon_q <= xtime(rcon_q);
          round_q <= last ? 4'd0 : round_q + 4'd1;
          if (last) begin
            st_q <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          st_q <= IDLE;
          round_q <= '0;
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          busy <= 1'b0;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_round_sched.sv
// tb_aes128_round_sched: directed FIPS-197 vectors, handshake, backpressure and reset checks
module tb_aes128_round_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic busy;
  logic [3:0] round_idx;
  int checks = 0, errors = 0;
  aes128_round_sched_if bus();
  aes128_round_sched dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .round_idx(round_idx));
  always #5 clk = ~clk;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1B = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic encrypt(input logic [127:0] k, input logic [127:0] p, output logic [127:0] ct, output int lat);
    bus.in_key = k;
    bus.in_block = p;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick;
      lat++;
    end
    ct = bus.out_data;
  endtask
  initial begin
    logic [127:0] ct;
    logic [127:0] got [2];
    int lat, na, nr;
    int acc [2];
    bus.in_valid = 1'b0;
    bus.in_key = '0;
    bus.in_block = '0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_round_idx", 128'(round_idx), 128'd0);
    chk("rst_rcon", 128'(dut.rcon_q), 128'h01);
    // C.1 with per-round sequence checks; out_ready high early has no effect
    bus.out_ready = 1'b1;
    bus.in_key = K1;
    bus.in_block = P1;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("c1_round_idx_%0d", i), 128'(round_idx), 128'(i));
      chk($sformatf("c1_rcon_%0d", i), 128'(dut.rcon_q), 128'(RCON[i-1]));
      chk($sformatf("c1_busy_%0d", i), 128'(busy), 128'd1);
      chk($sformatf("c1_in_ready_%0d", i), 128'(bus.in_ready), 128'd0);
      chk($sformatf("c1_out_valid_%0d", i), 128'(bus.out_valid), 128'd0);
      chk($sformatf("c1_out_data_hidden_%0d", i), bus.out_data, 128'd0);
      tick;
    end
    chk("c1_out_valid", 128'(bus.out_valid), 128'd1);
    chk("c1_out_data", bus.out_data, C1);
    chk("c1_done_round_idx", 128'(round_idx), 128'd0);
    chk("c1_done_busy", 128'(busy), 128'd1);
    tick;
    chk("c1_idle_in_ready", 128'(bus.in_ready), 128'd1);
    chk("c1_idle_out_valid", 128'(bus.out_valid), 128'd0);
    chk("c1_idle_out_data", bus.out_data, 128'd0);
    chk("c1_idle_busy", 128'(busy), 128'd0);
    // App. B with round-1 state check and backpressure
    bus.out_ready = 1'b0;
    bus.in_key = K2;
    bus.in_block = P2;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk("b_round1_state", dut.state_q, R1B);
    lat = 2;
    while (!bus.out_valid && lat < 40) begin
      tick;
      lat++;
    end
    chk("b_latency", 128'(lat), 128'd11);
    chk("b_out_data", bus.out_data, C2);
    bus.in_key = K1;
    bus.in_block = P1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      tick;
      chk($sformatf("bp_out_data_%0d", i), bus.out_data, C2);
      chk($sformatf("bp_out_valid_%0d", i), 128'(bus.out_valid), 128'd1);
      chk($sformatf("bp_in_ready_%0d", i), 128'(bus.in_ready), 128'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
    // Back-to-back with out_ready tied high
    na = 0;
    nr = 0;
    acc = '{0, 0};
    got = '{128'd0, 128'd0};
    for (int cyc = 0; cyc < 40 && nr < 2; cyc++) begin
      bus.in_key = (na == 0) ? K1 : K2;
      bus.in_block = (na == 0) ? P1 : P2;
      bus.in_valid = na < 2;
      if (bus.in_valid && bus.in_ready) begin
        acc[na] = cyc;
        na++;
      end
      if (bus.out_valid) begin
        got[nr] = bus.out_data;
        nr++;
      end
      tick;
    end
    bus.in_valid = 1'b0;
    chk("b2b_outputs", 128'(nr), 128'd2);
    chk("b2b_ct1", got[0], C1);
    chk("b2b_ct2", got[1], C2);
    chk("b2b_accept_gap", 128'(acc[1] - acc[0]), 128'd12);
    // Reset mid-ROUND, with in_valid asserted during reset
    bus.out_ready = 1'b0;
    bus.in_key = K1;
    bus.in_block = P1;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    repeat (4) tick;
    chk("mid_round_idx", 128'(round_idx), 128'd5);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_rst_out_data", bus.out_data, 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_round_idx", 128'(round_idx), 128'd0);
    chk("mid_rst_rcon", 128'(dut.rcon_q), 128'h01);
    bus.out_ready = 1'b1;
    encrypt(K1, P1, ct, lat);
    chk("post_rst_latency", 128'(lat), 128'd11);
    chk("post_rst_ct", ct, C1);
    tick;
    chk("post_rst_idle", 128'(bus.in_ready), 128'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
